serdes_cfg_loader: RTL and testbench
====================================

# serdes_cfg_loader

Consumes the per-frame configuration byte stream (O_config_data / O_config_en) produced by the serdes receive range/FIFO stage in the I_config_clk domain. Each contiguous enable burst is one frame. The block:
- validates header, length and checksum;
- buffers the payload;
- on a valid frame only, replays the payload as 16-bit register writes to the configuration register bank, then signals completion.

Invalid frames produce no writes.

## Interface
- FRAME_LEN, 180, bytes per frame; must be even and ≥ 6
- HDR0, 8'hA5, required byte 0
- HDR1, 8'h5A, required byte 1
- Derived: NWORDS = (FRAME_LEN-4)/2 (88 at default)

Ports:
- I_config_clk  in  1  clock; every port is synchronous to it
- I_sys_rst_n  in  1  asynchronous, active-low reset
- I_config_data  in  8  frame byte, valid when I_config_en=1
- I_config_en  in  1  byte strobe; one contiguous high run = one frame
- O_reg_wr  out  1  register write strobe
- O_reg_addr  out  7  word index, 0..NWORDS-1
- O_reg_data  out  16  word value: {byte 3+2k, byte 4+2k}, high byte first
- O_cfg_page  out  8  frame byte 2; valid and stable during commit
- O_load_done  out  1  one-cycle pulse when a commit completes
- O_frame_err  out  1  one-cycle pulse when a frame is rejected
- O_err_code  out  2  0=busy, 1=header, 2=length, 3=checksum; valid with O_frame_err and held until the next error
- O_frame_cnt  out  16  count of committed frames; wraps at 16'hFFFF→0

## Operation
- Frame layout: bytes 0–1 header, byte 2 page, bytes 3..FRAME_LEN-2 payload, byte FRAME_LEN-1 checksum.
- States:
  - IDLE: on en=1, go to RECV; the byte is index 0.
  - RECV: each en=1 byte does the following:
    - increments the 8-bit byte counter, saturating at 255;
    - adds the byte into the 8-bit running sum, except the checksum byte;
    - stores payload bytes into an internal array of FRAME_LEN-4 bytes;
    - latches header match flags at indices 0 and 1.

    On en=0, go to CHECK.
  - CHECK: one cycle. Error priority is length (count≠FRAME_LEN) > header > checksum.
    - On error: pulse O_frame_err with its code, go to IDLE.
    - Otherwise: go to COMMIT.
  - COMMIT: one word per cycle, k=0..NWORDS-1, with O_reg_wr=1. After the last word: pulse O_load_done, increment O_frame_cnt, go to IDLE.
  - DRAIN: entered when en=1 is seen during CHECK or COMMIT, after the current commit finishes.
    - Bytes arriving in DRAIN are discarded.
    - When en=0: pulse O_frame_err with code 0, go to IDLE.
    - A busy frame never corrupts the commit in progress.
- Bytes beyond index FRAME_LEN-1 are not stored; the frame ends as a length error.
- The running sum is modulo 256. The checksum passes when the sum of bytes 0..FRAME_LEN-2 equals byte FRAME_LEN-1.
- Reset:
  - Every output goes to 0: O_err_code=0, O_frame_cnt=0.
  - State returns to IDLE; counters and the sum are cleared.
  - The payload array is not cleared.
  - Reset asserted mid-RECV or mid-COMMIT aborts with no further writes. A frame whose en is still high at reset release is treated as a new frame starting at that byte; it then fails the length check.

## Timing
- All outputs are registered.
- Let E0 be the clock edge that samples the first en=0 after a frame; state=CHECK after E0.
- Valid frame:
  - O_reg_wr=1 with addr 0 is visible after E0+1; addr NWORDS-1 after E0+NWORDS.
  - O_load_done=1 and O_frame_cnt updated after E0+NWORDS+1.
  - A new frame is accepted from that cycle on.
- Invalid frame: O_frame_err is visible after E0+1 for exactly one cycle.
- Minimum inter-frame gap with no busy drop: NWORDS+2 cycles of en=0.
- O_cfg_page changes only on entry to COMMIT.

## Configuration
- CFG_LOADER_CHECKSUM_EN
  - Defined: checksum is verified as described above, and error code 3 is possible.
  - Undefined: the running-sum logic is omitted and the last byte is ignored. Header and length checks remain. Code 3 never occurs.

## Test plan
- Valid frame (A5 5A 07, payload bytes n=0..175 with value n, correct checksum) -> 88 writes on 88 consecutive cycles; addr0 data 16'h0001, addr87 data 16'hAEAF; O_cfg_page=8'h07; O_load_done one cycle after the last write; O_frame_cnt=1.
- Byte 0 = 8'hA4, otherwise valid -> no O_reg_wr; O_frame_err pulse with code 1; O_frame_cnt unchanged.
- 179-byte burst, and separately a 181-byte burst -> code 2, no writes.
- Checksum byte off by one -> code 3 when CFG_LOADER_CHECKSUM_EN is defined; with the macro undefined, a full commit occurs.
- Second frame starts 10 cycles after the first ends -> first frame commits all 88 words intact, then a code 0 pulse after the second frame's en falls; O_frame_cnt=1.
- Reset asserted at commit word 40 -> all outputs 0 while reset is asserted. After release and a new valid frame, 88 writes occur and O_frame_cnt=1.

Source files
------------

// File: rtl/serdes_cfg_loader_if.sv
// Configuration byte stream in, register-bank write port and frame status out.
interface serdes_cfg_loader_if;
  logic [7:0]  I_config_data;
  logic        I_config_en;
  logic        O_reg_wr;
  logic [6:0]  O_reg_addr;
  logic [15:0] O_reg_data;
  logic [7:0]  O_cfg_page;
  logic        O_load_done;
  logic        O_frame_err;
  logic [1:0]  O_err_code;
  logic [15:0] O_frame_cnt;

  modport master (
    output I_config_data, I_config_en,
    input  O_reg_wr, O_reg_addr, O_reg_data, O_cfg_page,
    input  O_load_done, O_frame_err, O_err_code, O_frame_cnt
  );

  modport slave (
    input  I_config_data, I_config_en,
    output O_reg_wr, O_reg_addr, O_reg_data, O_cfg_page,
    output O_load_done, O_frame_err, O_err_code, O_frame_cnt
  );
endinterface

// File: rtl/serdes_cfg_loader.sv
// Validates one config frame per enable burst and replays its payload as 16-bit register writes.
// Define CFG_LOADER_CHECKSUM_EN to verify the trailing modulo-256 checksum byte.
module serdes_cfg_loader #(
  parameter int         FRAME_LEN = 180,
  parameter logic [7:0] HDR0      = 8'hA5,
  parameter logic [7:0] HDR1      = 8'h5A
) (
  input  logic               I_config_clk,
  input  logic               I_sys_rst_n,
  serdes_cfg_loader_if.slave bus
);
  localparam int         PLEN   = FRAME_LEN - 4;
  localparam int         NWORDS = PLEN / 2;
  localparam logic [7:0] LEN_B  = 8'(FRAME_LEN);
  localparam logic [7:0] LAST_B = 8'(FRAME_LEN - 1);
  localparam logic [7:0] PEND_B = 8'(FRAME_LEN - 2);
  localparam logic [6:0] NW     = 7'(NWORDS);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_COMMIT, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hdr0_ok_q, hdr0_ok_d, hdr1_ok_q, hdr1_ok_d;
  logic [7:0]  page_buf_q, page_buf_d;
  logic        busy_q, busy_d;
  logic [6:0]  word_q, word_d;
  logic        reg_wr_q, reg_wr_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_data_q, reg_data_d;
  logic [7:0]  cfg_page_q, cfg_page_d;
  logic        load_done_q, load_done_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d, chk_q, chk_d;
`endif

  logic [7:0]  payload_mem [0:PLEN-1];
  logic        mem_we;
  logic [7:0]  mem_waddr, byte_idx, rd_base;
  logic [6:0]  rd_word;
  logic [15:0] rd_data;

  // Byte index of the incoming byte: IDLE always sees byte 0 of a new frame.
  assign byte_idx = (state_q == S_IDLE) ? 8'd0 : cnt_q;
  assign rd_word  = (state_q == S_CHECK) ? 7'd0 : word_q;
  assign rd_base  = (rd_word < NW) ? {rd_word, 1'b0} : 8'd0;
  assign rd_data  = {payload_mem[rd_base], payload_mem[rd_base + 8'd1]};

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr0_ok_d   = hdr0_ok_q;
    hdr1_ok_d   = hdr1_ok_q;
    page_buf_d  = page_buf_q;
    busy_d      = busy_q;
    word_d      = word_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    cfg_page_d  = cfg_page_q;
    load_done_d = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = byte_idx - 8'd3;
`ifdef CFG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    chk_d       = chk_q;
`endif
    unique case (state_q)
      S_IDLE, S_RECV: begin
        if (bus.I_config_en) begin
          state_d = S_RECV;
          cnt_d   = (byte_idx == 8'hFF) ? 8'hFF : byte_idx + 8'd1;
          if (byte_idx == 8'd0) begin
            hdr0_ok_d = (bus.I_config_data == HDR0);
            hdr1_ok_d = 1'b0;
            busy_d    = 1'b0;
          end
          if (byte_idx == 8'd1) hdr1_ok_d  = (bus.I_config_data == HDR1);
          if (byte_idx == 8'd2) page_buf_d = bus.I_config_data;
          mem_we = (byte_idx >= 8'd3) && (byte_idx <= PEND_B);
`ifdef CFG_LOADER_CHECKSUM_EN
          if (byte_idx == 8'd0)         sum_d = bus.I_config_data;
          else if (byte_idx != LAST_B)  sum_d = sum_q + bus.I_config_data;
          if (byte_idx == LAST_B)       chk_d = bus.I_config_data;
`endif
        end else if (state_q == S_RECV) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy_d = bus.I_config_en;
        if (cnt_q != LEN_B) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = S_IDLE;
        end else if (!(hdr0_ok_q && hdr1_ok_q)) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
          state_d     = S_IDLE;
`ifdef CFG_LOADER_CHECKSUM_EN
        end else if (sum_q != chk_q) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = S_IDLE;
`endif
        end else begin
          // Word 0 goes out on the same edge that enters COMMIT.
          state_d    = S_COMMIT;
          cfg_page_d = page_buf_q;
          reg_wr_d   = 1'b1;
          reg_addr_d = 7'd0;
          reg_data_d = rd_data;
          word_d     = 7'd1;
        end
      end
      S_COMMIT: begin
        if (bus.I_config_en) busy_d = 1'b1;
        if (word_q == NW) begin
          load_done_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = (busy_q || bus.I_config_en) ? S_DRAIN : S_IDLE;
        end else begin
          reg_wr_d   = 1'b1;
          reg_addr_d = word_q;
          reg_data_d = rd_data;
          word_d     = word_q + 7'd1;
        end
      end
      S_DRAIN: begin
        if (!bus.I_config_en) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_config_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hdr0_ok_q   <= 1'b0;
      hdr1_ok_q   <= 1'b0;
      page_buf_q  <= '0;
      busy_q      <= 1'b0;
      word_q      <= '0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      cfg_page_q  <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr0_ok_q   <= hdr0_ok_d;
      hdr1_ok_q   <= hdr1_ok_d;
      page_buf_q  <= page_buf_d;
      busy_q      <= busy_d;
      word_q      <= word_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      cfg_page_q  <= cfg_page_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_q       <= chk_d;
`endif
    end
  end

  // NOTE: the payload buffer has no reset; every byte is rewritten before a commit can read it.
  always_ff @(posedge I_config_clk) begin
    if (mem_we) payload_mem[mem_waddr] <= bus.I_config_data;
  end

  assign bus.O_reg_wr    = reg_wr_q;
  assign bus.O_reg_addr  = reg_addr_q;
  assign bus.O_reg_data  = reg_data_q;
  assign bus.O_cfg_page  = cfg_page_q;
  assign bus.O_load_done = load_done_q;
  assign bus.O_frame_err = frame_err_q;
  assign bus.O_err_code  = err_code_q;
  assign bus.O_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_serdes_cfg_loader.sv
// Directed bench for serdes_cfg_loader: valid, header, length, checksum, busy and reset-abort frames.
module tb_serdes_cfg_loader;
  localparam int         FRAME_LEN = 180;
  localparam logic [7:0] CHK       = 8'h2E;  // (A5+5A+07+sum(0..175)) mod 256

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serdes_cfg_loader_if bus();
  serdes_cfg_loader dut (.I_config_clk(clk), .I_sys_rst_n(rst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cnt, wr_first, wr_last, addr_bad, data_bad;
  int          done_cnt, done_cyc, err_cnt, err_cyc;
  logic [1:0]  code_seen;
  logic [15:0] d0, d87;

  always @(negedge clk) begin
    if (bus.O_reg_wr) begin
      if (wr_cnt == 0) wr_first = cyc;
      wr_last = cyc;
      if (bus.O_reg_addr !== 7'(wr_cnt)) addr_bad++;
      if (bus.O_reg_data !== {8'(2 * wr_cnt), 8'(2 * wr_cnt + 1)}) data_bad++;
      if (wr_cnt == 0)  d0  = bus.O_reg_data;
      if (wr_cnt == 87) d87 = bus.O_reg_data;
      wr_cnt++;
    end
    if (bus.O_load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.O_frame_err) begin
      err_cnt++;
      err_cyc   = cyc;
      code_seen = bus.O_err_code;
    end
  end

  task automatic clr();
    wr_cnt = 0; wr_first = -1; wr_last = -1; addr_bad = 0; data_bad = 0;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    code_seen = 2'bxx; d0 = 16'hxxxx; d87 = 16'hxxxx;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.O_reg_wr, bus.O_reg_addr, bus.O_reg_data, bus.O_cfg_page,
                bus.O_load_done, bus.O_frame_err, bus.O_err_code, bus.O_frame_cnt});
  endfunction

  function automatic logic [7:0] fbyte(input int idx, input logic [7:0] b0, input logic [7:0] dchk);
    if (idx == 0) return b0;
    if (idx == 1) return 8'h5A;
    if (idx == 2) return 8'h07;
    if (idx < FRAME_LEN - 1) return 8'(idx - 3);
    if (idx == FRAME_LEN - 1) return CHK + dchk;
    return 8'hEE;
  endfunction

  // Returns e0: the cycle number after the edge that samples the first en=0.
  task automatic send_frame(input int len, input logic [7:0] b0, input logic [7:0] dchk, output int e0);
    for (int i = 0; i < len; i++) begin
      bus.I_config_en   = 1'b1;
      bus.I_config_data = fbyte(i, b0, dchk);
      tick();
    end
    bus.I_config_en   = 1'b0;
    bus.I_config_data = 8'h00;
    e0 = cyc + 1;
  endtask

  int e0, e0b, snap, exp_cnt;

  initial begin
    bus.I_config_en   = 1'b0;
    bus.I_config_data = 8'h00;
    clr();
    rst_n = 1'b0;
    tick(3);
    check("reset_outputs", outs(), 64'd0);
    check("reset_frame_cnt", 64'(bus.O_frame_cnt), 64'd0);
    rst_n = 1'b1;
    tick(2);
    exp_cnt = 0;

    // Valid frame, cycle-exact timing relative to E0
    clr();
    send_frame(FRAME_LEN, 8'hA5, 8'd0, e0);
    tick(100);
    exp_cnt++;
    check("valid_wr_count", 64'(wr_cnt), 64'd88);
    check("valid_first_wr", 64'(wr_first), 64'(e0 + 1));
    check("valid_last_wr", 64'(wr_last), 64'(e0 + 88));
    check("valid_addr0_data", 64'(d0), 64'h0001);
    check("valid_addr87_data", 64'(d87), 64'hAEAF);
    check("valid_addr_seq", 64'(addr_bad), 64'd0);
    check("valid_data_all", 64'(data_bad), 64'd0);
    check("valid_page", 64'(bus.O_cfg_page), 64'h07);
    check("valid_done_count", 64'(done_cnt), 64'd1);
    check("valid_done_cyc", 64'(done_cyc), 64'(e0 + 89));
    check("valid_frame_cnt", 64'(bus.O_frame_cnt), 64'(exp_cnt));
    check("valid_no_err", 64'(err_cnt), 64'd0);

    // Bad header byte 0
    clr();
    send_frame(FRAME_LEN, 8'hA4, 8'd0, e0);
    tick(10);
    check("hdr_no_wr", 64'(wr_cnt), 64'd0);
    check("hdr_err_count", 64'(err_cnt), 64'd1);
    check("hdr_err_cyc", 64'(err_cyc), 64'(e0 + 1));
    check("hdr_code", 64'(code_seen), 64'd1);
    check("hdr_code_held", 64'(bus.O_err_code), 64'd1);
    check("hdr_frame_cnt", 64'(bus.O_frame_cnt), 64'(exp_cnt));

    // Short frame
    clr();
    send_frame(FRAME_LEN - 1, 8'hA5, 8'd0, e0);
    tick(10);
    check("short_no_wr", 64'(wr_cnt), 64'd0);
    check("short_err_count", 64'(err_cnt), 64'd1);
    check("short_code", 64'(code_seen), 64'd2);

    // Long frame
    clr();
    send_frame(FRAME_LEN + 1, 8'hA5, 8'd0, e0);
    tick(10);
    check("long_no_wr", 64'(wr_cnt), 64'd0);
    check("long_err_count", 64'(err_cnt), 64'd1);
    check("long_err_cyc", 64'(err_cyc), 64'(e0 + 1));
    check("long_code", 64'(code_seen), 64'd2);

    // Checksum byte off by one
    clr();
    send_frame(FRAME_LEN, 8'hA5, 8'd1, e0);
    tick(100);
`ifdef CFG_LOADER_CHECKSUM_EN
    check("chk_no_wr", 64'(wr_cnt), 64'd0);
    check("chk_code", 64'(code_seen), 64'd3);
    check("chk_err_count", 64'(err_cnt), 64'd1);
`else
    exp_cnt++;
    check("chk_ignored_wr", 64'(wr_cnt), 64'd88);
    check("chk_ignored_data", 64'(data_bad), 64'd0);
    check("chk_ignored_done", 64'(done_cnt), 64'd1);
    check("chk_ignored_no_err", 64'(err_cnt), 64'd0);
`endif
    check("chk_frame_cnt", 64'(bus.O_frame_cnt), 64'(exp_cnt));

    // Second frame arrives during the commit of the first
    clr();
    send_frame(FRAME_LEN, 8'hA5, 8'd0, e0);
    tick(10);
    send_frame(FRAME_LEN, 8'hA5, 8'd0, e0b);
    tick(20);
    exp_cnt++;
    check("busy_wr_count", 64'(wr_cnt), 64'd88);
    check("busy_data_all", 64'(data_bad), 64'd0);
    check("busy_addr_seq", 64'(addr_bad), 64'd0);
    check("busy_last_wr", 64'(wr_last), 64'(e0 + 88));
    check("busy_done_count", 64'(done_cnt), 64'd1);
    check("busy_err_count", 64'(err_cnt), 64'd1);
    check("busy_code", 64'(code_seen), 64'd0);
    check("busy_err_after_fall", 64'(err_cyc >= e0b && err_cyc <= e0b + 1), 64'd1);
    check("busy_frame_cnt", 64'(bus.O_frame_cnt), 64'(exp_cnt));

    // Reset asserted mid-commit
    clr();
    send_frame(FRAME_LEN, 8'hA5, 8'd0, e0);
    for (int i = 0; i < 200 && wr_cnt < 40; i++) tick();
    check("rstc_reached_word40", 64'(wr_cnt >= 40), 64'd1);
    rst_n = 1'b0;
    #1;
    snap = wr_cnt;
    check("rstc_outputs_now", outs(), 64'd0);
    tick(3);
    check("rstc_outputs_held", outs(), 64'd0);
    check("rstc_no_more_wr", 64'(wr_cnt), 64'(snap));
    rst_n = 1'b1;
    tick(2);
    check("rstc_after_release", outs(), 64'd0);
    clr();
    send_frame(FRAME_LEN, 8'hA5, 8'd0, e0);
    tick(100);
    check("rstc_new_wr_count", 64'(wr_cnt), 64'd88);
    check("rstc_new_data_all", 64'(data_bad), 64'd0);
    check("rstc_new_done", 64'(done_cnt), 64'd1);
    check("rstc_new_frame_cnt", 64'(bus.O_frame_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
